reflet_lsu: RTL and testbench

- Parametrised load/store sequencer between the Reflet core and memory. It succeeds the fixed-timing address unit.
- Accepts one memory command at a time: a fetch, load or store, of size byte, half or word, at any address.
- Drives a req/ack memory bus with byte enables, so memory may insert any number of wait states.
- Returns read data right-aligned and zero-extended. Misaligned or oversize accesses are rejected with an error and never reach the bus.

---
 rtl/reflet_lsu_pkg.sv | 31 +++
 rtl/reflet_lsu_lanes.sv | 42 ++++
 rtl/reflet_lsu.sv | 169 ++++++++++++++++
 tb/tb_reflet_lsu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_lsu_pkg.sv
// reflet_lsu_pkg: shared definitions for the Reflet load/store sequencer.
//   - state_e : sequencer FSM states
//   - size_e  : cmd_size encodings (log2 of access bytes)
//   - ERR_*   : rsp_err codes
//   - size_bytes() : access size in bytes for a cmd_size value
package reflet_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD32 = 2'd2,
    SIZE_WORD64 = 2'd3
  } size_e;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_SIZE     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/reflet_lsu_lanes.sv
// reflet_lsu_lanes: combinational byte-lane steering for a WORDSIZE-wide bus.
// Shared with the instruction fetch path.
// Ports:
//   lane        in  byte offset of the access inside the bus word
//   size        in  log2 of access bytes
//   wdata       in  right-aligned store data
//   rdata       in  raw bus read data
//   be          out byte enables for the access
//   wdata_steer out store data shifted onto its lanes
//   rdata_ext   out read data shifted down, masked to the access size
module reflet_lsu_lanes
  import reflet_lsu_pkg::*;
#(
  parameter int WORDSIZE = 16,
  localparam int BYTES = WORDSIZE / 8,
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic [LANE_W-1:0]   lane,
  input  logic [1:0]          size,
  input  logic [WORDSIZE-1:0] wdata,
  input  logic [WORDSIZE-1:0] rdata,
  output logic [BYTES-1:0]    be,
  output logic [WORDSIZE-1:0] wdata_steer,
  output logic [WORDSIZE-1:0] rdata_ext
);

  logic [BYTES-1:0]    be_base;
  logic [WORDSIZE-1:0] rd_shift;

  always_comb begin
    be_base   = '0;
    rdata_ext = '0;
    rd_shift  = rdata >> (8 * int'(lane));
    for (int i = 0; i < BYTES; i++) begin
      be_base[i] = (i < size_bytes(size));
      if (be_base[i]) rdata_ext[8*i +: 8] = rd_shift[8*i +: 8];
    end
    be          = be_base << lane;
    wdata_steer = wdata << (8 * int'(lane));
  end

endmodule

// File: rtl/reflet_lsu.sv
// reflet_lsu: load/store sequencer between the Reflet core and a req/ack
// memory bus. One command in flight; misaligned or oversize commands are
// answered with an error without touching the bus.
// Optional build macro: REFLET_LSU_TIMEOUT_EN adds parameter TIMEOUT and a
// WAIT-state watchdog that answers err=3 when memory never acks.
// Ports:
//   clk, reset (async, active-low), enable (global run enable)
//   cmd_valid/cmd_ready, cmd_we, cmd_size, cmd_addr, cmd_wdata : command
//   rsp_valid, rsp_data, rsp_err : one-cycle completion
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata, mem_rdata, mem_ack : bus
// Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready;
// a bus access completes on an edge where mem_req && mem_ack; the request is
// held stable until then.
module reflet_lsu
  import reflet_lsu_pkg::*;
#(
  parameter int WORDSIZE = 16
`ifdef REFLET_LSU_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [1:0]            cmd_size,
  input  logic [WORDSIZE-1:0]   cmd_addr,
  input  logic [WORDSIZE-1:0]   cmd_wdata,
  output logic                  rsp_valid,
  output logic [WORDSIZE-1:0]   rsp_data,
  output logic [1:0]            rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORDSIZE-1:0]   mem_addr,
  output logic [WORDSIZE/8-1:0] mem_be,
  output logic [WORDSIZE-1:0]   mem_wdata,
  input  logic [WORDSIZE-1:0]   mem_rdata,
  input  logic                  mem_ack
);

  localparam int BYTES  = WORDSIZE / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [WORDSIZE-1:0] ADDR_MASK = ~WORDSIZE'(BYTES - 1);

  state_e state, state_next;

  logic                we_q;
  logic [1:0]          size_q;
  logic [WORDSIZE-1:0] addr_q, wdata_q, data_q;
  logic [1:0]          err_q, acc_err;
  logic [LANE_W-1:0]   lane;
  logic [BYTES-1:0]    lane_be;
  logic [WORDSIZE-1:0] lane_wdata, lane_rdata;
  logic                accept, ack_hit;

  assign cmd_ready = (state == ST_IDLE) && enable;
  assign accept    = cmd_valid && cmd_ready;
  assign ack_hit   = (state == ST_WAIT) && mem_req && mem_ack;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_data  = rsp_valid ? data_q : '0;
  assign rsp_err   = rsp_valid ? err_q : ERR_OK;

  if (BYTES > 1) begin : g_lane
    assign lane = addr_q[LANE_W-1:0];
  end else begin : g_nolane
    assign lane = '0;
  end

  // Oversize takes priority over misalignment.
  always_comb begin
    acc_err = ERR_OK;
    if (size_bytes(cmd_size) > BYTES) acc_err = ERR_SIZE;
    else if ((int'(cmd_addr[2:0]) & (size_bytes(cmd_size) - 1)) != 0) acc_err = ERR_MISALIGN;
  end

`ifdef REFLET_LSU_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       tmo_hit;
  // An ack in the expiry cycle takes precedence over the timeout.
  assign tmo_hit = (state == ST_WAIT) && !ack_hit && (tcnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tcnt <= '0;
    else if (state == ST_ISSUE) tcnt <= '0;
    else if ((state == ST_WAIT) && !ack_hit) tcnt <= tcnt + 8'd1;
  end
`endif

  reflet_lsu_lanes #(.WORDSIZE(WORDSIZE)) u_lanes (
    .lane        (lane),
    .size        (size_q),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .be          (lane_be),
    .wdata_steer (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // WAIT keeps watching the bus even with enable low; other states freeze.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = (acc_err != ERR_OK) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (enable) state_next = ST_WAIT;
      ST_WAIT: begin
        if (ack_hit) state_next = ST_RESP;
`ifdef REFLET_LSU_TIMEOUT_EN
        else if (tmo_hit) state_next = ST_RESP;
`endif
      end
      ST_RESP:  if (enable) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= ERR_OK;
      data_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) begin
        we_q    <= cmd_we;
        size_q  <= cmd_size;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        err_q   <= acc_err;
        data_q  <= '0;
      end
      if ((state == ST_ISSUE) && enable) begin
        mem_req   <= 1'b1;
        mem_we    <= we_q;
        mem_be    <= lane_be;
        mem_addr  <= addr_q & ADDR_MASK;
        mem_wdata <= lane_wdata;
      end
      if (ack_hit) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        mem_be  <= '0;
        if (!we_q) data_q <= lane_rdata;
      end
`ifdef REFLET_LSU_TIMEOUT_EN
      else if (tmo_hit) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        mem_be  <= '0;
        err_q   <= ERR_TIMEOUT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reflet_lsu.sv
// tb_reflet_lsu: self-checking bench for reflet_lsu at WORDSIZE=32.
module tb_reflet_lsu;

  localparam int W = 32;
`ifdef REFLET_LSU_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [1:0]    cmd_size;
  logic [W-1:0]  cmd_addr, cmd_wdata;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic [1:0]    rsp_err;
  logic          mem_req, mem_we;
  logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
  logic [W/8-1:0] mem_be;
  logic          mem_ack;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference memory (byte-addressed by the low address byte) and expected queue.
  logic [7:0]   mem_bytes [0:255];
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  reflet_lsu #(
    .WORDSIZE(W)
`ifdef REFLET_LSU_TIMEOUT_EN
    , .TIMEOUT(TB_TIMEOUT)
`endif
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // One full command: drives it at a negedge, plays the memory with `waits`
  // no-ack request cycles before the ack, and checks every cycle.
  task automatic do_cmd(input logic we, input logic [1:0] size, input logic [W-1:0] addr,
                        input logic [W-1:0] wdata, input int waits);
    int sb, lane, c, base;
    logic [1:0]   e_err;
    logic [W-1:0] e_data, e_wdata, e_rdword, got;
    logic [3:0]   e_be;
    bit           timed_out;
    sb   = 1 << size;
    lane = int'(addr[1:0]);
    base = int'(addr[7:0]) & ~3;
    e_err = (sb > 4) ? 2'd2 : ((int'(addr[2:0]) % sb) != 0) ? 2'd1 : 2'd0;
    timed_out = 1'b0;
`ifdef REFLET_LSU_TIMEOUT_EN
    if (e_err == 2'd0 && waits >= TB_TIMEOUT) begin
      timed_out = 1'b1;
      e_err = 2'd3;
    end
`endif
    e_data = '0;
    e_be   = '0;
    if (e_err == 2'd0 || timed_out) begin
      for (int k = 0; k < sb; k++) begin
        e_be[lane + k] = 1'b1;
        if (!we && !timed_out) e_data[8*k +: 8] = mem_bytes[int'(addr[7:0]) + k];
      end
    end
    e_wdata  = wdata << (8 * lane);
    e_rdword = {mem_bytes[base+3], mem_bytes[base+2], mem_bytes[base+1], mem_bytes[base]};
    exp_q.push_back(e_data);

    cmd_valid = 1'b1; cmd_we = we; cmd_size = size; cmd_addr = addr; cmd_wdata = wdata;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_errs++; $display("FAIL accept_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_size = 2'($urandom);
    cmd_addr = $urandom; cmd_wdata = $urandom;

    if (e_err == 2'd0 || timed_out) begin
      n_checks++;
      if ({cmd_ready, rsp_valid, mem_req} !== 3'b000) begin
        n_errs++; $display("FAIL issue_cycle: ready/rsp/req=%b want 000", {cmd_ready, rsp_valid, mem_req});
      end
      @(negedge clk);
      c = 0;
      while (1) begin
        n_checks++;
        if ({mem_req, mem_we, mem_be, cmd_ready, rsp_valid} !== {1'b1, we, e_be, 2'b00} ||
            mem_addr !== (addr & ~32'h3) || mem_wdata !== e_wdata) begin
          n_errs++;
          $display("FAIL bus_req c=%0d: req=%b we=%b be=%b addr=%h wd=%h rdy=%b rv=%b want req=1 we=%b be=%b addr=%h wd=%h rdy=0 rv=0",
                   c, mem_req, mem_we, mem_be, mem_addr, mem_wdata, cmd_ready, rsp_valid,
                   we, e_be, addr & ~32'h3, e_wdata);
        end
        if (c == waits) begin mem_ack = 1'b1; mem_rdata = e_rdword; end
        else begin mem_ack = 1'b0; mem_rdata = $urandom; end
        @(negedge clk);
        mem_ack = 1'b0;
        if (c == waits) break;
        c++;
`ifdef REFLET_LSU_TIMEOUT_EN
        if (c == TB_TIMEOUT) break;
`endif
      end
      if (we && !timed_out)
        for (int k = 0; k < sb; k++) mem_bytes[int'(addr[7:0]) + k] = wdata[8*k +: 8];
    end

    // Response cycle: scoreboard pop.
    got = '0;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errs++; $display("FAIL scoreboard: expected queue empty");
    end else begin
      got = exp_q.pop_front();
      if (rsp_valid !== 1'b1 || rsp_err !== e_err || rsp_data !== got ||
          {mem_req, mem_we, mem_be} !== 6'b0) begin
        n_errs++;
        $display("FAIL rsp: valid=%b err=%0d data=%h req/we/be=%b want valid=1 err=%0d data=%h req/we/be=0",
                 rsp_valid, rsp_err, rsp_data, {mem_req, mem_we, mem_be}, e_err, got);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_errs++; $display("FAIL after_rsp: rsp_valid/cmd_ready=%b want 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_size = '0;
    cmd_addr = '0; cmd_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, rsp_valid, mem_req, mem_we, mem_be} !== 8'b1000_0000 ||
        rsp_data !== '0 || rsp_err !== 2'd0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_errs++; $display("FAIL reset_outputs: rdy=%b rv=%b req=%b be=%b data=%h", cmd_ready, rsp_valid, mem_req, mem_be, rsp_data);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_errs++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_enable;
    enable = 1'b0; cmd_valid = 1'b1; cmd_size = 2'd2; cmd_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({cmd_ready, mem_req, rsp_valid} !== 3'b000) begin
        n_errs++; $display("FAIL enable_low: rdy/req/rv=%b want 000", {cmd_ready, mem_req, rsp_valid});
      end
    end
    cmd_valid = 1'b0; enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    do_cmd(1'b1, 2'd0, 32'h0000_0007, 32'h0000_00A5, 0);   // store byte A5 -> lane 3
    do_cmd(1'b0, 2'd0, 32'h0000_0007, 32'h0, 0);           // load it back
    do_cmd(1'b1, 2'd1, 32'h0000_0102, 32'h0000_BEEF, 0);
    do_cmd(1'b0, 2'd1, 32'h0000_0102, 32'h0, 1);
    do_cmd(1'b0, 2'd2, 32'h1234_5600, 32'h0, 0);
  endtask

  task automatic test_errors;
    do_cmd(1'b0, 2'd1, 32'h0000_0003, 32'h0, 0);   // misaligned half
    do_cmd(1'b0, 2'd3, 32'h0000_0000, 32'h0, 0);   // 64-bit on 32-bit bus
    do_cmd(1'b1, 2'd2, 32'h0000_0006, 32'hFFFF_FFFF, 0);
    do_cmd(1'b1, 2'd3, 32'h0000_0005, 32'h1, 0);   // oversize wins over misaligned
  endtask

  task automatic test_wait_states;
    do_cmd(1'b0, 2'd2, 32'h0000_0020, 32'h0, 5);
    do_cmd(1'b1, 2'd0, 32'h0000_0021, 32'h0000_005A, 5);
  endtask

  task automatic test_reset_mid_wait;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h10;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin n_errs++; $display("FAIL mid_wait_req: got %b want 1", mem_req); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin n_errs++; $display("FAIL async_reset_req: got %b want 0", mem_req); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, mem_req, cmd_ready} !== 3'b001) begin
        n_errs++; $display("FAIL post_reset: rv/req/rdy=%b want 001", {rsp_valid, mem_req, cmd_ready});
      end
    end
    do_cmd(1'b0, 2'd2, 32'h0000_0010, 32'h0, 0);
  endtask

  task automatic test_random;
    logic [1:0]   sz;
    logic [W-1:0] a;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      do_cmd(1'($urandom), sz, a, $urandom, $urandom_range(0, 3));
    end
  endtask

`ifdef REFLET_LSU_TIMEOUT_EN
  task automatic test_timeout;
    do_cmd(1'b0, 2'd2, 32'h0000_0030, 32'h0, 1000);  // never acks
    do_cmd(1'b0, 2'd2, 32'h0000_0030, 32'h0, TB_TIMEOUT - 1);  // ack in last cycle wins
    do_cmd(1'b1, 2'd1, 32'h0000_0032, 32'h0000_1234, 1000);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem_bytes[i] = 8'($urandom);
    test_reset();
    test_enable();
    test_directed();
    test_errors();
    test_wait_states();
    test_reset_mid_wait();
    test_random();
`ifdef REFLET_LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
